// File: rtl/mem_unit_pkg.sv
// mem_unit_pkg: shared widths, load/TLB opcode encodings and bundle layouts
// for the MEM stage. The struct field order is the bundle bit order, MSB first.
package mem_unit_pkg;

    localparam int EXE2MEM_LEN = 212;
    localparam int MEM2WB_LEN  = 207;

    localparam logic [2:0] MEM_OP_B  = 3'b000;
    localparam logic [2:0] MEM_OP_H  = 3'b001;
    localparam logic [2:0] MEM_OP_W  = 3'b010;
    localparam logic [2:0] MEM_OP_BU = 3'b100;
    localparam logic [2:0] MEM_OP_HU = 3'b101;

    localparam logic [2:0] TLB_OP_NONE = 3'd0;
    localparam logic [2:0] TLB_OP_SRCH = 3'd1;
    localparam logic [2:0] TLB_OP_RD   = 3'd2;
    localparam logic [2:0] TLB_OP_WR   = 3'd3;
    localparam logic [2:0] TLB_OP_FILL = 3'd4;
    localparam logic [2:0] TLB_OP_INV  = 3'd5;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] alu_result;
        logic [31:0] pc;
        logic        res_from_mem;
        logic [2:0]  mem_op;
        logic        req_issued;
        logic        csr_read;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic [31:0] vaddr;
        logic        ex_valid;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        is_ertn;
        logic [2:0]  tlb_op;
        logic [4:0]  invtlb_op;
    } exe2mem_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] final_result;
        logic [31:0] pc;
        logic        csr_read;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic [31:0] vaddr;
        logic        ex_valid;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        is_ertn;
        logic [2:0]  tlb_op;
        logic [4:0]  invtlb_op;
    } mem2wb_t;

endpackage

// File: rtl/mem_unit_if.sv
// mem_unit_if: every non-clock signal of the MEM stage.
// Handshake: a bundle moves EXE->MEM on a cycle where exe_to_mem_valid and
// mem_allowin are both high, and MEM->WBU on a cycle where mem_to_wb_valid
// and wb_allowin are both high; valid never depends on allowin of the same
// link, and a bundle offered but not taken stays in place.
interface mem_unit_if;
    logic                                 mem_allowin;
    logic                                 exe_to_mem_valid;
    logic [mem_unit_pkg::EXE2MEM_LEN-1:0] exe_to_mem_zip;
    logic                                 wb_allowin;
    logic                                 mem_to_wb_valid;
    logic [mem_unit_pkg::MEM2WB_LEN-1:0]  mem_to_wb_zip;
    logic                                 data_sram_data_ok;
    logic [31:0]                          data_sram_rdata;
    logic                                 exe_req_pending;
    logic                                 wb_ex;
    logic                                 mem_ex;
    logic [38:0]                          mem_rf_zip;
    logic [31:0]                          mem_stall_cnt;

    // MEM stage view
    modport master (
        input  exe_to_mem_valid, exe_to_mem_zip, wb_allowin,
        input  data_sram_data_ok, data_sram_rdata, exe_req_pending, wb_ex,
        output mem_allowin, mem_to_wb_valid, mem_to_wb_zip,
        output mem_ex, mem_rf_zip, mem_stall_cnt
    );

    // Surrounding pipeline view
    modport slave (
        output exe_to_mem_valid, exe_to_mem_zip, wb_allowin,
        output data_sram_data_ok, data_sram_rdata, exe_req_pending, wb_ex,
        input  mem_allowin, mem_to_wb_valid, mem_to_wb_zip,
        input  mem_ex, mem_rf_zip, mem_stall_cnt
    );
endinterface

// File: rtl/mem_load_ext.sv
// mem_load_ext: selects the addressed byte/half of a load word and extends it.
module mem_load_ext
    import mem_unit_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  off,
    input  logic [2:0]  mem_op,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select by address offset, then sign/zero extension by opcode
    always_comb begin
        byte_sel = raw[7:0];
        case (off)
            2'd1:    byte_sel = raw[15:8];
            2'd2:    byte_sel = raw[23:16];
            2'd3:    byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
        half_sel = off[1] ? raw[31:16] : raw[15:0];
        load_data = raw;
        case (mem_op)
            MEM_OP_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            MEM_OP_BU: load_data = {24'd0, byte_sel};
            MEM_OP_H:  load_data = {{16{half_sel[15]}}, half_sel};
            MEM_OP_HU: load_data = {16'd0, half_sel};
            default:   load_data = raw;
        endcase
    end

endmodule

// File: rtl/mem_unit.sv
// mem_unit: MEM pipeline stage. Latches EXE results, waits for the data
// response of loads issued in EXE, drops responses owed to flushed
// instructions, and forwards results to ID and WBU.
// Optional build macro MEMU_STALL_CNT_EN adds a free-running stall counter.
module mem_unit
    import mem_unit_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    mem_unit_if.master bus
);

    exe2mem_t    in_zip;
    exe2mem_t    zip_q, zip_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] data_buf_q, data_buf_d;
    logic        data_buf_valid_q, data_buf_valid_d;
    logic [1:0]  discard_cnt_q, discard_cnt_d;

    logic        wait_data, resp_own, resp_drop, wait_unanswered;
    logic        mem_ready_go, allowin, capture;
    logic [2:0]  discard_sum;
    logic [31:0] raw, load_data, final_result;
    mem2wb_t     out_zip;

    assign in_zip = bus.exe_to_mem_zip;

    assign wait_data       = mem_valid_q & zip_q.req_issued & ~data_buf_valid_q;
    assign resp_own        = bus.data_sram_data_ok & (discard_cnt_q == 2'd0);
    assign resp_drop       = bus.data_sram_data_ok & (discard_cnt_q != 2'd0);
    assign wait_unanswered = wait_data & ~resp_own;
    assign mem_ready_go    = ~wait_data | resp_own;
    assign allowin         = ~mem_valid_q | (mem_ready_go & bus.wb_allowin);
    assign capture         = bus.exe_to_mem_valid & allowin;

    // Responses still owed to flushed loads: the one MEM was waiting for plus
    // the one EXE has in flight, less any drop happening this cycle
    assign discard_sum = {1'b0, discard_cnt_q} + {2'b00, wait_unanswered}
                       + {2'b00, bus.exe_req_pending} - {2'b00, resp_drop};

    // Next-state: flush beats capture; otherwise capture/drain plus buffering
    always_comb begin
        mem_valid_d      = mem_valid_q;
        zip_d            = zip_q;
        data_buf_d       = data_buf_q;
        data_buf_valid_d = data_buf_valid_q;
        discard_cnt_d    = discard_cnt_q;
        if (resp_own) begin
            data_buf_d = bus.data_sram_rdata;
        end
        if (bus.wb_ex) begin
            mem_valid_d      = 1'b0;
            data_buf_valid_d = 1'b0;
            discard_cnt_d    = (discard_sum > 3'd2) ? 2'd2 : discard_sum[1:0];
        end else begin
            if (capture) begin
                mem_valid_d      = 1'b1;
                zip_d            = in_zip;
                data_buf_valid_d = 1'b0;
            end else begin
                if (mem_ready_go & bus.wb_allowin) begin
                    mem_valid_d = 1'b0;
                end
                if (resp_own & wait_data & ~bus.wb_allowin) begin
                    data_buf_valid_d = 1'b1;
                end
            end
            if (resp_drop) begin
                discard_cnt_d = discard_cnt_q - 2'd1;
            end
        end
    end

    // Stage state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q      <= 1'b0;
            zip_q            <= '0;
            data_buf_q       <= 32'd0;
            data_buf_valid_q <= 1'b0;
            discard_cnt_q    <= 2'd0;
        end else begin
            mem_valid_q      <= mem_valid_d;
            zip_q            <= zip_d;
            data_buf_q       <= data_buf_d;
            data_buf_valid_q <= data_buf_valid_d;
            discard_cnt_q    <= discard_cnt_d;
        end
    end

    assign raw = data_buf_valid_q ? data_buf_q : bus.data_sram_rdata;

    mem_load_ext u_load_ext (
        .raw       (raw),
        .off       (zip_q.alu_result[1:0]),
        .mem_op    (zip_q.mem_op),
        .load_data (load_data)
    );

    assign final_result = zip_q.res_from_mem ? load_data : zip_q.alu_result;

    assign out_zip.rf_we        = zip_q.rf_we;
    assign out_zip.rf_waddr     = zip_q.rf_waddr;
    assign out_zip.final_result = final_result;
    assign out_zip.pc           = zip_q.pc;
    assign out_zip.csr_read     = zip_q.csr_read;
    assign out_zip.csr_we       = zip_q.csr_we;
    assign out_zip.csr_num      = zip_q.csr_num;
    assign out_zip.csr_wmask    = zip_q.csr_wmask;
    assign out_zip.csr_wvalue   = zip_q.csr_wvalue;
    assign out_zip.vaddr        = zip_q.vaddr;
    assign out_zip.ex_valid     = zip_q.ex_valid;
    assign out_zip.ecode        = zip_q.ecode;
    assign out_zip.esubcode     = zip_q.esubcode;
    assign out_zip.is_ertn      = zip_q.is_ertn;
    assign out_zip.tlb_op       = zip_q.tlb_op;
    assign out_zip.invtlb_op    = zip_q.invtlb_op;

    assign bus.mem_allowin     = allowin;
    assign bus.mem_to_wb_valid = mem_valid_q & mem_ready_go & ~bus.wb_ex;
    assign bus.mem_to_wb_zip   = out_zip;
    assign bus.mem_ex          = mem_valid_q & (zip_q.ex_valid | zip_q.is_ertn);
    assign bus.mem_rf_zip      = {mem_valid_q & (zip_q.res_from_mem | zip_q.csr_read),
                                  mem_valid_q & zip_q.rf_we & ~zip_q.ex_valid,
                                  zip_q.rf_waddr, final_result};

`ifdef MEMU_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count cycles an instruction sits in MEM waiting for load data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= 32'd0;
        end else if (mem_valid_q & ~mem_ready_go) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.mem_stall_cnt = stall_cnt_q;
`else
    assign bus.mem_stall_cnt = 32'd0;
`endif

endmodule

// File: doc/mem_unit.md
# mem_unit

Memory-access pipeline stage (MEM) between EXE and WBU in the LoongArch core. Latches EXE results, waits for the data SRAM-like response of loads issued in EXE, and aligns and extends load data. Drops responses that belong to flushed instructions. Forwards results to ID and packs `mem_to_wb_zip` for WBU.

## Interface
- `EXE2MEM_LEN`: default from `macros.h`; width of the EXE→MEM bundle.
- `MEM2WB_LEN`: default from `macros.h`; width of the MEM→WB bundle, field order fixed by WBU.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `mem_allowin`  out  1  MEM can accept an instruction this cycle.
- `exe_to_mem_valid`  in  1  EXE offers an instruction.
- `exe_to_mem_zip`  in  `EXE2MEM_LEN`  in order:
  - `rf_we`, `rf_waddr`[5], `alu_result`[32], `pc`[32]
  - `res_from_mem`, `mem_op`[3], `req_issued`
  - `csr_read`, `csr_we`, `csr_num`[14], `csr_wmask`[32], `csr_wvalue`[32]
  - `vaddr`[32], `ex_valid`, `ecode`[6], `esubcode`[9], `is_ertn`
  - `tlb_op`[3], `invtlb_op`[5]
- `wb_allowin`  in  1  WBU accepts.
- `mem_to_wb_valid`  out  1  bundle valid toward WBU.
- `mem_to_wb_zip`  out  `MEM2WB_LEN`  in order:
  - `rf_we`, `rf_waddr`, `final_result`, `pc`
  - `csr_read`, `csr_we`, `csr_num`, `csr_wmask`, `csr_wvalue`
  - `vaddr`, `ex_valid`, `ecode`, `esubcode`, `is_ertn`
  - `tlb_op`, `invtlb_op`
- `data_sram_data_ok`  in  1  read/write response strobe.
- `data_sram_rdata`  in  32  read data, valid with `data_ok`.
- `exe_req_pending`  in  1  EXE holds an issued request whose response has not returned.
- `wb_ex`  in  1  WBU exception/ERTN flush.
- `mem_ex`  out  1  `mem_valid & (ex_valid | is_ertn)`; EXE suppresses new memory requests while it is high.
- `mem_rf_zip`  out  39  `{mem_blocking, rf_we_fwd, rf_waddr, final_result}` forwarded to ID.
- `mem_stall_cnt`  out  32  stall cycle counter; see Configuration.

## Operation
- Registers:
  - `mem_valid`
  - latched zip fields
  - `data_buf[31:0]` and `data_buf_valid` (response arrived while WBU was not accepting)
  - `discard_cnt[1:0]` (responses still to be dropped)
- `wait_data = mem_valid & req_issued & ~data_buf_valid`.
- `resp_own = data_sram_data_ok & (discard_cnt == 0)`.
- `resp_drop = data_sram_data_ok & (discard_cnt != 0)`.
- Ready and handshake:
  - `mem_ready_go = ~wait_data | resp_own`.
  - `mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin)`.
  - `mem_to_wb_valid = mem_valid & mem_ready_go & ~wb_ex`.
- Capture: on `exe_to_mem_valid & mem_allowin`, latch the zip and set `mem_valid`, clearing `data_buf_valid`. Otherwise, when `mem_ready_go & wb_allowin`, clear `mem_valid`.
- Response buffering: on `resp_own & wait_data & ~wb_allowin`, set `data_buf_valid`. `data_buf` captures `data_sram_rdata` on every `resp_own`.
- Load data source: `raw = data_buf_valid ? data_buf : data_sram_rdata`.
- Load extension, using `off = alu_result[1:0]`:
  - LD.B / LD.BU: byte `raw[8*off +: 8]`, sign- or zero-extended.
  - LD.H / LD.HU: half `raw[16*off[1] +: 16]`, sign- or zero-extended.
  - LD.W: `raw`.
- `final_result = res_from_mem ? load_data : alu_result`.
- Forwarding:
  - `mem_blocking = mem_valid & (res_from_mem | csr_read)`.
  - `rf_we_fwd = mem_valid & rf_we & ~ex_valid`.
  - When `res_from_mem` and `~mem_ready_go`, ID must stall; `final_result` is don't-care.
- Flush on `wb_ex`:
  - Clear `mem_valid` and `data_buf_valid`.
  - Next `discard_cnt = discard_cnt + wait_data_unanswered + exe_req_pending − resp_drop`, where `wait_data_unanswered = wait_data & ~resp_own`.
  - A `resp_own` arriving in the flush cycle is consumed and not counted.
- Without flush: `discard_cnt` decrements on `resp_drop`, saturating at 0. It never exceeds 2.
- MEM generates no exceptions itself; all exception fields pass through unchanged.

## Timing
- Non-load instruction: 1 cycle in MEM.
- Load: the response may arrive in the first MEM cycle, giving zero stall.
- `wb_ex` takes effect combinationally on `mem_to_wb_valid` and at the next edge on the state.
- Reset values:
  - `mem_valid`, `data_buf_valid`, `discard_cnt`, all latched fields and `mem_stall_cnt` are 0.
  - Consequently `mem_to_wb_valid = 0`, `mem_ex = 0`, `mem_rf_zip = 0`, and `mem_allowin = 1`.
- Reset asserted mid-load clears everything. Any later response is then treated as owned by the next load; the system resets the SRAM side together with the core.

## Configuration
- `MEMU_STALL_CNT_EN` defined: `mem_stall_cnt` increments each cycle with `mem_valid & ~mem_ready_go`, wrapping at 2^32.
- Not defined: the port is tied to 0 and no counter flop exists.

## Structure
- `macros.h` holds:
  - `EXE2MEM_LEN` and `MEM2WB_LEN`
  - `MEM_OP_{B,H,W,BU,HU}` encodings
  - `TLB_OP_*`
- Sub-module `mem_load_ext` is combinational: inputs `raw`, `off`, `mem_op`; output `load_data`.

## Test plan
- LD.W at `0x1000`, `data_ok` in the first cycle with `rdata = 0xDEADBEEF` → WBU receives `final_result = 0xDEADBEEF` after 1 cycle.
- LD.B with `off = 3`, `rdata = 0x80FF_0000` → `0xFFFFFF80`. LD.HU with `off = 2` on the same data → `0x000080FF`.
- Load whose `data_ok` arrives 3 cycles late with `wb_allowin = 0` for 2 further cycles → `data_buf` holds the value, `mem_to_wb_valid` is held, `mem_stall_cnt = 3` when the macro is defined.
- `wb_ex` while a load waits and `exe_req_pending = 1` → `discard_cnt = 2`. The next two `data_ok` pulses are ignored and the third feeds the new load.
- `ex_valid = 1` with `ecode = 0x0B` entering MEM → `mem_ex = 1`, `rf_we_fwd = 0`, and the fields pass through to WBU unchanged.
